// File: rtl/br_pkg.sv
// Shared types and defaults for the branch resolve unit.
// FSM state encoding and datapath width defaults.
package br_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } br_state_t;

    localparam int XLEN_DEF    = 32;
    localparam int PC_STEP_DEF = 4;

endpackage

// File: rtl/branch_resolve_ctrl_cmp.sv
// Branch comparator: equality-based outcome for BEQ/BNE.
// Both flags set means always taken, neither means never taken.
module branch_resolve_ctrl_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            bne,
    input  logic            beq,
    output logic            taken
);

    logic eq;

    assign eq    = (a == b);
    assign taken = (~eq & bne) | (eq & beq);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve sequencer: latch, compare, check static prediction, redirect.
// Optional macro BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_ctrl
    import br_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [XLEN-1:0] br_a,
    input  logic [XLEN-1:0] br_b,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            br_beq,
    input  logic            br_bne,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            flush,
    output logic            resolved,
    output logic            resolved_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    br_state_t       state;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic            beq_q;
    logic            bne_q;
    logic            taken_q;

    logic            taken;
    logic            pred;
    logic [XLEN-1:0] target;

    branch_resolve_ctrl_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .a     (a_q),
        .b     (b_q),
        .bne   (bne_q),
        .beq   (beq_q),
        .taken (taken)
    );

    // Static prediction: backward branches predicted taken.
    assign pred     = imm_q[XLEN-1];
    assign target   = taken ? (pc_q + imm_q) : (pc_q + XLEN'(PC_STEP));
    assign br_ready = (state == IDLE);

    // Main FSM with registered redirect and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            pc_q           <= '0;
            imm_q          <= '0;
            beq_q          <= 1'b0;
            bne_q          <= 1'b0;
            taken_q        <= 1'b0;
            redir_valid    <= 1'b0;
            redir_pc       <= '0;
            flush          <= 1'b0;
            resolved       <= 1'b0;
            resolved_taken <= 1'b0;
        end else begin
            flush    <= 1'b0;
            resolved <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (br_valid) begin
                        a_q   <= br_a;
                        b_q   <= br_b;
                        pc_q  <= br_pc;
                        imm_q <= br_imm;
                        beq_q <= br_beq;
                        bne_q <= br_bne;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (taken == pred) begin
                        resolved       <= 1'b1;
                        resolved_taken <= taken;
                        state          <= IDLE;
                    end else begin
                        redir_pc    <= target;
                        redir_valid <= 1'b1;
                        taken_q     <= taken;
                        state       <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redir_valid && redir_ready) begin
                        redir_valid    <= 1'b0;
                        flush          <= 1'b1;
                        resolved       <= 1'b1;
                        resolved_taken <= taken_q;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counters driven by the registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolved && (stat_branches != '1))
                stat_branches <= stat_branches + 32'd1;
            if (flush && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: driver pushes expected
// resolutions, a negedge monitor pops and compares them.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        reset;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] br_a;
    logic [31:0] br_b;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        br_beq;
    logic        br_bne;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        flush;
    logic        resolved;
    logic        resolved_taken;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolve_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_a           (br_a),
        .br_b           (br_b),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .br_beq         (br_beq),
        .br_bne         (br_bne),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .redir_ready    (redir_ready),
        .flush          (flush),
        .resolved       (resolved),
        .resolved_taken (resolved_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        bit          mis;
        logic [31:0] rpc;
        bit          taken;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          hs_cyc = -1;
    logic        prev_rv = 1'b0;
    logic [31:0] held = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        fails++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (redir_valid && !prev_rv) begin
                if (q.size() == 0) bad("redir_unexp");
                else begin
                    chk("redir_pc", redir_pc, q[0].rpc);
                    chk("redir_is_mis", 32'(q[0].mis), 32'd1);
                    chk("redir_lat", cyc, q[0].acc + 1);
                    held = redir_pc;
                end
            end else if (redir_valid) begin
                chk("redir_hold", redir_pc, held);
            end
            if (resolved) begin
                if (q.size() == 0) bad("resolved_unexp");
                else begin
                    e = q.pop_front();
                    chk("res_taken", 32'(resolved_taken), 32'(e.taken));
                    chk("res_flush", 32'(flush), 32'(e.mis));
                    chk("res_rv_low", 32'(redir_valid), 32'd0);
                    if (e.mis) chk("flush_lat", cyc, hs_cyc);
                    else chk("res_lat", cyc, e.acc + 1);
                end
            end else if (flush) begin
                bad("flush_alone");
            end
        end
        prev_rv = redir_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic beq, input logic bne,
                       input bit mis, input logic [31:0] rpc,
                       input bit taken, input int hold,
                       input bit complete);
        int n;
        exp_t e;
        n = 0;
        while (!br_ready && n < 20) begin tick(); n++; end
        if (n == 20) bad("timeout_ready");
        br_a = a; br_b = b; br_pc = pc; br_imm = imm;
        br_beq = beq; br_bne = bne; br_valid = 1'b1;
        redir_ready = !mis;
        e.mis = mis; e.rpc = rpc; e.taken = taken; e.acc = cyc + 1;
        q.push_back(e);
        tick();
        br_valid = 1'b0;
        chk("ready_eval", 32'(br_ready), 32'd0);
        if (mis) begin
            n = 0;
            while (!redir_valid && n < 20) begin tick(); n++; end
            if (n == 20) bad("timeout_redir");
            for (int i = 0; i < hold; i++) tick();
            if (!complete) return;
            redir_ready = 1'b1;
            hs_cyc = cyc + 1;
            tick();
            redir_ready = 1'b0;
        end
        n = 0;
        while (q.size() != 0 && n < 20) begin tick(); n++; end
        if (n == 20) bad("timeout_resolve");
        redir_ready = 1'b0;
    endtask

    // Driver: directed vectors with hand-computed outcomes.
    initial begin
        int c;
        exp_t e;
        reset = 1'b1; br_valid = 1'b0; redir_ready = 1'b0;
        br_a = '0; br_b = '0; br_pc = '0; br_imm = '0;
        br_beq = 1'b0; br_bne = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_rv", 32'(redir_valid), 32'd0);
        chk("rst_rpc", redir_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_res", 32'(resolved), 32'd0);
        chk("rst_rtaken", 32'(resolved_taken), 32'd0);
        reset = 1'b0;
        tick();

        run(32'd5, 32'd7, 32'h100, 32'd16, 1, 0, 0, 32'h0, 0, 0, 1);
        run(32'd9, 32'd9, 32'h100, 32'd16, 1, 0, 1, 32'h110, 1, 3, 1);
        run(32'd3, 32'd3, 32'h200, -32'sd8, 0, 1, 1, 32'h204, 0, 1, 1);
`ifdef BRANCH_STATS_EN
        tick();
        chk("stat_branches", stat_branches, 32'd3);
        chk("stat_mispredicts", stat_mispredicts, 32'd2);
`endif
        run(32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8, 1, 0, 1, 32'h4, 1, 0, 1);
        run(32'd1, 32'd2, 32'h40, -32'sd16, 1, 1, 0, 32'h0, 1, 0, 1);
        run(32'd6, 32'd6, 32'h80, -32'sd4, 0, 0, 1, 32'h84, 0, 2, 1);

        c = 0;
        while (!br_ready && c < 20) begin tick(); c++; end
        br_a = 32'd1; br_b = 32'd2; br_pc = 32'h300; br_imm = -32'sd4;
        br_beq = 1'b0; br_bne = 1'b1; br_valid = 1'b1;
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            e.mis = 0; e.rpc = '0; e.taken = 1; e.acc = c + 1 + 2 * k;
            q.push_back(e);
        end
        for (int k = 0; k < 6; k++) begin
            chk("b2b_ready", 32'(br_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k == 5) br_valid = 1'b0;
            else tick();
        end
        c = 0;
        while (q.size() != 0 && c < 20) begin tick(); c++; end
        if (c == 20) bad("timeout_b2b");

        run(32'd9, 32'd9, 32'h100, 32'd16, 1, 0, 1, 32'h110, 1, 1, 0);
        chk("pre_rst_rv", 32'(redir_valid), 32'd1);
        reset = 1'b1;
        q.delete();
        tick();
        reset = 1'b0;
        chk("mid_rst_rv", 32'(redir_valid), 32'd0);
        chk("mid_rst_ready", 32'(br_ready), 32'd1);
        chk("mid_rst_rpc", redir_pc, 32'd0);
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_res", 32'(resolved), 32'd0);
        for (int i = 0; i < 4; i++) tick();

        run(32'd0, 32'd0, 32'h500, 32'd12, 1, 0, 1, 32'h50C, 1, 0, 1);
        chk("final_q_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
